tdc_sum_avg: RTL and testbench
==============================

TDC_SUM_AVG -- requirements
Module: tdc_sum_avg

Interface
REQ-001 Parameter: IN_W, 37, width of the summed TDC word from the adder-tree stage.
REQ-002 Parameter: MAX_LOG2, 10, largest supported window exponent (window = 2^n frames).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sum_in  input  IN_W  summed TDC word from the upstream adder tree.
REQ-006 sum_dval  input  1  one-cycle qualifier for sum_in; no backpressure upstream.
REQ-007 win_log2  input  4  window exponent n.
REQ-008 clear  input  1  synchronous abort of current window and clear of overrun.
REQ-009 avg_data  output  IN_W  window mean, floor((sum of 2^n samples) >> n).
REQ-010 avg_min / avg_max  output  IN_W each  smallest / largest sample of the window.
REQ-011 avg_valid  output  1  result held valid until accepted.
REQ-012 avg_ready  input  1  downstream accept; transfer when avg_valid && avg_ready.
REQ-013 busy  output  1  high while state is ACC.
REQ-014 overrun  output  1  sticky flag: a completed window was discarded.

Function
REQ-015 The FSM SHALL have two states: IDLE (no samples held) and ACC (1 to 2^n-1 samples held).
REQ-016 On sum_dval in IDLE: latch n = min(win_log2, MAX_LOG2), acc = sum_in, cnt = 1, min = max = sum_in; go to ACC, or complete immediately if n = 0.
REQ-017 win_log2 changes SHALL take effect only at the first sample of a window.
REQ-018 On sum_dval in ACC: acc += sum_in (zero-extended), cnt++, update min/max; on the 2^n-th sample, complete and return to IDLE in the same cycle.
REQ-019 The accumulator SHALL be IN_W+MAX_LOG2 bits (47) and never wrap.
REQ-020 Division SHALL be a right shift by n with truncation (no rounding).
REQ-021 Completion on cycle k SHALL load avg_data/min/max and assert avg_valid at k+1 (latency 1).
REQ-022 Back-to-back windows SHALL need no idle cycles; a sample on cycle k+1 starts the next window.
REQ-023 avg_valid SHALL clear the cycle after a transfer, unless a new result loads in the same cycle.
REQ-024 Load with a transfer in the same cycle: the new result replaces the old, avg_valid stays 1, no overrun.
REQ-025 Completion while avg_valid=1 and no transfer: new result discarded, output unchanged, overrun set.
REQ-026 clear SHALL return FSM to IDLE, zero acc/cnt/min/max, and clear overrun; the output register and avg_valid are unaffected.
REQ-027 clear with sum_dval in the same cycle: clear wins, sample discarded.
REQ-028 avg_data/min/max SHALL be stable while avg_valid=1 and avg_ready=0.

Reset
REQ-029 On rst low: state IDLE, acc = 0, cnt = 0, n = 0, avg_data = avg_min = avg_max = 0, avg_valid = 0, busy = 0, overrun = 0.
REQ-030 A reset mid-window SHALL discard all partial samples; the first sample after release starts a fresh window.

Verification
REQ-031 n=2, ready=1, samples 100, 200, 300, 401 -> 1 cycle after 4th: avg_data = 250, min = 100, max = 401, one valid pulse.
REQ-032 n=0, sample 12345 each cycle for 3 cycles, ready=1 -> avg_data = 12345 every cycle, avg_valid held high.
REQ-033 n=10, 1024 samples of 2^37-1 -> avg_data = 2^37-1, no wrap; busy high from sample 1 to 1023.
REQ-034 n=0, ready=0, samples 5 then 7 -> avg_data stays 5, overrun = 1; after ready pulse and clear -> avg_valid = 0, overrun = 0.
REQ-035 n=3, 3 samples of 99 then clear, then 8 samples of 8 -> avg_data = 8, min = max = 8.
REQ-036 rst asserted after 2 of 4 samples (n=2), then 4 samples of 40 -> avg_data = 40, all outputs 0 during reset.

Source files
------------

// File: rtl/tdc_sum_avg.sv
// Windowed mean / min / max of summed TDC words over 2^n frames.
// Results sit in a valid/ready output register; a finished window with nowhere to go sets a sticky overrun.
module tdc_sum_avg #(
    parameter int IN_W     = 37,
    parameter int MAX_LOG2 = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] sum_in,
    input  logic            sum_dval,
    input  logic [3:0]      win_log2,
    input  logic            clear,
    output logic [IN_W-1:0] avg_data,
    output logic [IN_W-1:0] avg_min,
    output logic [IN_W-1:0] avg_max,
    output logic            avg_valid,
    input  logic            avg_ready,
    output logic            busy,
    output logic            overrun,
    output logic            state_dbg
);

    localparam int ACC_W = IN_W + MAX_LOG2;
    localparam int CNT_W = MAX_LOG2 + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        n_q;
    logic [IN_W-1:0]   cur_min;
    logic [IN_W-1:0]   cur_max;

    logic [3:0]        n_eff;
    logic [3:0]        n_use;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  acc_shift;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  win_len;
    logic [IN_W-1:0]   smp_min;
    logic [IN_W-1:0]   smp_max;
    logic              take;
    logic              done;
    logic              load_ok;

    // Output handshake: a result transfers on any cycle where avg_valid && avg_ready;
    // the output register only reloads when it is empty or being drained that same cycle.
    always_comb begin
        n_eff     = (win_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : win_log2;
        n_use     = (state == IDLE) ? n_eff : n_q;
        acc_next  = ((state == IDLE) ? '0 : acc) + ACC_W'(sum_in);
        cnt_next  = ((state == IDLE) ? '0 : cnt) + CNT_W'(1);
        win_len   = CNT_W'(1) << n_use;
        smp_min   = (state == IDLE || sum_in < cur_min) ? sum_in : cur_min;
        smp_max   = (state == IDLE || sum_in > cur_max) ? sum_in : cur_max;
        acc_shift = acc_next >> n_use;
        take      = sum_dval && !clear;
        done      = take && (cnt_next == win_len);
        load_ok   = !avg_valid || avg_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            n_q       <= '0;
            cur_min   <= '0;
            cur_max   <= '0;
            busy      <= 1'b0;
            avg_data  <= '0;
            avg_min   <= '0;
            avg_max   <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Window accumulation; clear beats a coincident sample.
            if (clear || done) begin
                state   <= IDLE;
                acc     <= '0;
                cnt     <= '0;
                cur_min <= '0;
                cur_max <= '0;
                busy    <= 1'b0;
            end else if (take) begin
                state   <= ACC;
                acc     <= acc_next;
                cnt     <= cnt_next;
                n_q     <= n_use;
                cur_min <= smp_min;
                cur_max <= smp_max;
                busy    <= 1'b1;
            end

            if (done && load_ok) begin
                avg_data  <= acc_shift[IN_W-1:0];
                avg_min   <= smp_min;
                avg_max   <= smp_max;
                avg_valid <= 1'b1;
            end else if (avg_valid && avg_ready) begin
                avg_valid <= 1'b0;
            end

            if (clear) begin
                overrun <= 1'b0;
            end else if (done && !load_ok) begin
                overrun <= 1'b1;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_tdc_sum_avg.sv
// Directed bench for tdc_sum_avg: hand-computed windows, overrun, clear and reset cases.
module tb_tdc_sum_avg;

    localparam int IN_W     = 37;
    localparam int MAX_LOG2 = 10;

    logic            clk;
    logic            rst;
    logic [IN_W-1:0] sum_in;
    logic            sum_dval;
    logic [3:0]      win_log2;
    logic            clear;
    logic [IN_W-1:0] avg_data;
    logic [IN_W-1:0] avg_min;
    logic [IN_W-1:0] avg_max;
    logic            avg_valid;
    logic            avg_ready;
    logic            busy;
    logic            overrun;
    logic            state_dbg;

    int tests_run;
    int tests_failed;

    logic [IN_W-1:0] all_ones;

    tdc_sum_avg #(.IN_W(IN_W), .MAX_LOG2(MAX_LOG2)) dut (
        .clk      (clk),
        .rst      (rst),
        .sum_in   (sum_in),
        .sum_dval (sum_dval),
        .win_log2 (win_log2),
        .clear    (clear),
        .avg_data (avg_data),
        .avg_min  (avg_min),
        .avg_max  (avg_max),
        .avg_valid(avg_valid),
        .avg_ready(avg_ready),
        .busy     (busy),
        .overrun  (overrun),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // one sample per call; consecutive calls are back-to-back
    task automatic sample(input logic [IN_W-1:0] v);
        sum_in   = v;
        sum_dval = 1'b1;
        tick();
        sum_dval = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        all_ones     = '1;
        rst       = 1'b0;
        sum_in    = '0;
        sum_dval  = 1'b0;
        win_log2  = 4'd0;
        clear     = 1'b0;
        avg_ready = 1'b1;
        repeat (2) tick();
        check("rst_data", 64'(avg_data), 64'd0);
        check("rst_valid", 64'(avg_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        rst = 1'b1;
        tick();

        // n=2 window; win_log2 change mid-window must be ignored
        win_log2 = 4'd2;
        sample(37'd100);
        check("w4_busy1", 64'(busy), 64'd1);
        win_log2 = 4'd0;
        sample(37'd200);
        sample(37'd300);
        check("w4_nvalid", 64'(avg_valid), 64'd0);
        sample(37'd401);
        check("w4_valid", 64'(avg_valid), 64'd1);
        check("w4_data", 64'(avg_data), 64'd250);
        check("w4_min", 64'(avg_min), 64'd100);
        check("w4_max", 64'(avg_max), 64'd401);
        check("w4_busy0", 64'(busy), 64'd0);
        tick();
        check("w4_pulse", 64'(avg_valid), 64'd0);

        // n=0 back-to-back, ready held
        win_log2 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            sample(37'd12345);
            check("n0_valid", 64'(avg_valid), 64'd1);
            check("n0_data", 64'(avg_data), 64'd12345);
        end
        tick();
        check("n0_drop", 64'(avg_valid), 64'd0);

        // n=10, full-scale samples, no wrap
        win_log2 = 4'd10;
        for (int i = 1; i <= 1024; i++) begin
            sample(all_ones);
            if (i == 1)    check("big_busy1", 64'(busy), 64'd1);
            if (i == 1023) check("big_busy1023", 64'(busy), 64'd1);
        end
        check("big_data", 64'(avg_data), 64'(all_ones));
        check("big_valid", 64'(avg_valid), 64'd1);
        check("big_busy0", 64'(busy), 64'd0);
        tick();

        // overrun with ready low, then drain and clear
        win_log2  = 4'd0;
        avg_ready = 1'b0;
        sample(37'd5);
        check("ovr_data5", 64'(avg_data), 64'd5);
        check("ovr_flag0", 64'(overrun), 64'd0);
        sample(37'd7);
        check("ovr_keep", 64'(avg_data), 64'd5);
        check("ovr_flag1", 64'(overrun), 64'd1);
        check("ovr_valid", 64'(avg_valid), 64'd1);
        avg_ready = 1'b1;
        tick();
        avg_ready = 1'b0;
        check("ovr_drain", 64'(avg_valid), 64'd0);
        check("ovr_sticky", 64'(overrun), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr_clr_flag", 64'(overrun), 64'd0);
        check("ovr_clr_valid", 64'(avg_valid), 64'd0);
        avg_ready = 1'b1;

        // clear aborts window; sample coincident with clear is dropped
        win_log2 = 4'd3;
        for (int i = 0; i < 3; i++) sample(37'd99);
        check("clr_busy1", 64'(busy), 64'd1);
        clear    = 1'b1;
        sum_in   = 37'd99;
        sum_dval = 1'b1;
        tick();
        clear    = 1'b0;
        sum_dval = 1'b0;
        check("clr_busy0", 64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) sample(37'd8);
        check("clr_valid", 64'(avg_valid), 64'd1);
        check("clr_data", 64'(avg_data), 64'd8);
        check("clr_min", 64'(avg_min), 64'd8);
        check("clr_max", 64'(avg_max), 64'd8);
        tick();

        // async reset mid-window
        win_log2 = 4'd2;
        sample(37'd1000);
        sample(37'd1000);
        check("mr_busy1", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("mr_data", 64'(avg_data), 64'd0);
        check("mr_min", 64'(avg_min), 64'd0);
        check("mr_max", 64'(avg_max), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_valid", 64'(avg_valid), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) sample(37'd40);
        check("mr_after_valid", 64'(avg_valid), 64'd1);
        check("mr_after_data", 64'(avg_data), 64'd40);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
